// File: rtl/arm_defs.sv
// Shared ARM pipeline definitions: instruction classes, opcodes, ALU
// commands, the execute-stage control bundle and the memory FSM states.
package arm_defs;

  // Instruction class carried in the mode field
  localparam logic [1:0] ARITHMETIC = 2'b00;
  localparam logic [1:0] MEM        = 2'b01;
  localparam logic [1:0] BRANCH     = 2'b10;

  // Data-processing opcodes
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  // ALU commands driven into EX
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_CMP = 4'b0100;
  localparam logic [3:0] EXE_TST = 4'b0110;
  localparam logic [3:0] EXE_NOP = 4'b0000;

  // Execute-stage control bundle
  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       mem_read;
    logic       mem_write;
    logic       wb_en;
    logic       s_out;
    logic       b;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{exe_cmd: EXE_NOP, default: 1'b0};

  // Memory-access FSM
  typedef enum logic {IDLE, MEM_WAIT} state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: mode/op_code/S to the EX control
// bundle, plus illegal-encoding and memory-op flags.
module ctrl_decode
  import arm_defs::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] op_code,
  input  logic       s_in,
  output ctrl_t      ctrl,
  output logic       illegal,
  output logic       is_mem
);

  // Decode table; anything unrecognised collapses to a NOP flagged illegal
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    is_mem  = 1'b0;
    case (mode)
      ARITHMETIC: begin
        ctrl.s_out = s_in;
        ctrl.wb_en = 1'b1;
        case (op_code)
          OP_MOV:  ctrl.exe_cmd = EXE_MOV;
          OP_MVN:  ctrl.exe_cmd = EXE_MVN;
          OP_ADD:  ctrl.exe_cmd = EXE_ADD;
          OP_ADC:  ctrl.exe_cmd = EXE_ADC;
          OP_SUB:  ctrl.exe_cmd = EXE_SUB;
          OP_SBC:  ctrl.exe_cmd = EXE_SBC;
          OP_AND:  ctrl.exe_cmd = EXE_AND;
          OP_ORR:  ctrl.exe_cmd = EXE_ORR;
          OP_EOR:  ctrl.exe_cmd = EXE_EOR;
          OP_CMP: begin
            ctrl.exe_cmd = EXE_CMP;
            ctrl.wb_en   = 1'b0;
          end
          OP_TST: begin
            ctrl.exe_cmd = EXE_TST;
            ctrl.wb_en   = 1'b0;
          end
          default: begin
            ctrl    = CTRL_NOP;
            illegal = 1'b1;
          end
        endcase
      end
      MEM: begin
        // Address generation uses the adder; S selects load vs store
        is_mem         = 1'b1;
        ctrl.exe_cmd   = EXE_ADD;
        ctrl.mem_read  = s_in;
        ctrl.wb_en     = s_in;
        ctrl.mem_write = ~s_in;
      end
      BRANCH: begin
        ctrl.b = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID/EX control register with bubble/squash handling and a multi-cycle
// memory FSM that holds EX and stalls upstream while a load/store completes.
module ctrl_pipe_unit
  import arm_defs::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic       s_in,
  input  logic [1:0] mode,
  input  logic [3:0] op_code,
  input  logic       cond_pass,
  input  logic       hazard,
  input  logic       flush,
  output logic       ex_valid,
  output logic [3:0] exe_cmd,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_en,
  output logic       s_out,
  output logic       b,
  output logic       illegal,
  output logic       stall_out
);

  ctrl_t             ctrl_p0;
  logic              illegal_p0;
  logic              is_mem_p0;
  logic              bubble_p0;
  logic              take_mem_p0;

  ctrl_t             ctrl_p1;
  logic              vld_p1;
  logic              illegal_p1;
  state_t            state;
  logic [CNT_W-1:0]  cnt;

  ctrl_decode u_decode (
    .mode    (mode),
    .op_code (op_code),
    .s_in    (s_in),
    .ctrl    (ctrl_p0),
    .illegal (illegal_p0),
    .is_mem  (is_mem_p0)
  );

  // ---- ID stage (p0): bubble selection and memory-op detection ----
  assign bubble_p0   = flush | hazard | ~valid_in;
  assign take_mem_p0 = ~bubble_p0 & is_mem_p0 & cond_pass;

  // ID/EX register and memory FSM; MEM_WAIT freezes EX so the access
  // in progress is never cancelled, not even by a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_p1    <= CTRL_NOP;
      vld_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
    end else if (state == MEM_WAIT) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) state <= IDLE;
    end else begin
      if (bubble_p0) begin
        ctrl_p1    <= CTRL_NOP;
        vld_p1     <= 1'b0;
        illegal_p1 <= 1'b0;
      end else if (illegal_p0) begin
        ctrl_p1    <= CTRL_NOP;
        vld_p1     <= 1'b1;
        illegal_p1 <= 1'b1;
      end else if (!cond_pass) begin
        ctrl_p1    <= CTRL_NOP;
        vld_p1     <= 1'b1;
        illegal_p1 <= 1'b0;
      end else begin
        ctrl_p1    <= ctrl_p0;
        vld_p1     <= 1'b1;
        illegal_p1 <= 1'b0;
      end
      if (take_mem_p0 && (MEM_LAT > 1)) begin
        state <= MEM_WAIT;
        cnt   <= CNT_W'(MEM_LAT - 1);
      end
    end
  end

  // ---- EX stage (p1): registered controls out ----
  assign ex_valid  = vld_p1;
  assign exe_cmd   = ctrl_p1.exe_cmd;
  assign mem_read  = ctrl_p1.mem_read;
  assign mem_write = ctrl_p1.mem_write;
  assign wb_en     = ctrl_p1.wb_en;
  assign s_out     = ctrl_p1.s_out;
  assign b         = ctrl_p1.b;
  assign illegal   = illegal_p1;

  // Nothing is frozen while held in reset; otherwise hazard stalls in the
  // same cycle and MEM_WAIT stalls for the remainder of the access
  assign stall_out = rst_n & (hazard | (state == MEM_WAIT));

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: two instances (MEM_LAT 3 and 4)
// share stimulus; per-cycle expectations for both are queued and compared.
module tb_ctrl_pipe_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in, s_in, cond_pass, hazard, flush;
  logic [1:0] mode;
  logic [3:0] op_code;

  logic       ex_valid3, mem_read3, mem_write3, wb_en3, s_out3, b3, illegal3, stall3;
  logic [3:0] exe_cmd3;
  logic       ex_valid4, mem_read4, mem_write4, wb_en4, s_out4, b4, illegal4, stall4;
  logic [3:0] exe_cmd4;

  logic [11:0] obs3, obs4;

  typedef struct {
    string       tag;
    logic [11:0] e3;
    logic [11:0] e4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.MEM_LAT(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .s_in(s_in), .mode(mode),
    .op_code(op_code), .cond_pass(cond_pass), .hazard(hazard), .flush(flush),
    .ex_valid(ex_valid3), .exe_cmd(exe_cmd3), .mem_read(mem_read3),
    .mem_write(mem_write3), .wb_en(wb_en3), .s_out(s_out3), .b(b3),
    .illegal(illegal3), .stall_out(stall3)
  );

  ctrl_pipe_unit #(.MEM_LAT(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .s_in(s_in), .mode(mode),
    .op_code(op_code), .cond_pass(cond_pass), .hazard(hazard), .flush(flush),
    .ex_valid(ex_valid4), .exe_cmd(exe_cmd4), .mem_read(mem_read4),
    .mem_write(mem_write4), .wb_en(wb_en4), .s_out(s_out4), .b(b4),
    .illegal(illegal4), .stall_out(stall4)
  );

  assign obs3 = {ex_valid3, exe_cmd3, mem_read3, mem_write3, wb_en3, s_out3, b3, illegal3, stall3};
  assign obs4 = {ex_valid4, exe_cmd4, mem_read4, mem_write4, wb_en4, s_out4, b4, illegal4, stall4};

  // {ex_valid, exe_cmd, mem_read, mem_write, wb_en, s_out, b, illegal, stall_out}
  function automatic logic [11:0] ex(input logic v, input logic [3:0] cmd,
                                     input logic mr, input logic mw, input logic wb,
                                     input logic s, input logic br, input logic ill,
                                     input logic st);
    return {v, cmd, mr, mw, wb, s, br, ill, st};
  endfunction

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b (v cmd mr mw wb s b ill stall)", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic s, input logic [1:0] md, input logic [3:0] op,
                     input logic cp, input logic hz, input logic fl);
    valid_in = v; s_in = s; mode = md; op_code = op; cond_pass = cp; hazard = hz; flush = fl;
  endtask

  task automatic compare_head();
    exp_t it;
    it = sb.pop_front();
    check_val({it.tag, "_lat3"}, obs3, it.e3);
    check_val({it.tag, "_lat4"}, obs4, it.e4);
  endtask

  // Queue the expectation, let one rising edge pass, compare away from it
  task automatic cyc(input string tag, input logic [11:0] e3, input logic [11:0] e4);
    sb.push_back('{tag, e3, e4});
    @(posedge clk);
    #1;
    compare_head();
  endtask

  // Expectation for the present instant, without an edge in between
  task automatic now(input string tag, input logic [11:0] e3, input logic [11:0] e4);
    sb.push_back('{tag, e3, e4});
    #1;
    compare_head();
  endtask

  logic [11:0] ldr, str, add0, nop_st, bub;

  initial begin
    ldr    = ex(1, 4'b0010, 1, 0, 1, 0, 0, 0, 1);
    str    = ex(1, 4'b0010, 0, 1, 0, 0, 0, 0, 1);
    add0   = ex(1, 4'b0010, 0, 0, 1, 0, 0, 0, 0);
    nop_st = ex(0, 4'b0000, 0, 0, 0, 0, 0, 0, 1);
    bub    = ex(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0);

    // Reset with every input high
    rst_n = 1'b0;
    drv(1, 1, 2'b11, 4'b1111, 1, 1, 1);
    cyc("reset_a", 12'h0, 12'h0);
    cyc("reset_b", 12'h0, 12'h0);
    rst_n = 1'b1;

    // Arithmetic decode
    drv(1, 1, 2'b00, 4'b0100, 1, 0, 0);
    cyc("add", ex(1, 4'b0010, 0, 0, 1, 1, 0, 0, 0), ex(1, 4'b0010, 0, 0, 1, 1, 0, 0, 0));
    drv(1, 1, 2'b00, 4'b1010, 1, 0, 0);
    cyc("cmp", ex(1, 4'b0100, 0, 0, 0, 1, 0, 0, 0), ex(1, 4'b0100, 0, 0, 0, 1, 0, 0, 0));
    drv(1, 0, 2'b00, 4'b1000, 1, 0, 0);
    cyc("tst", ex(1, 4'b0110, 0, 0, 0, 0, 0, 0, 0), ex(1, 4'b0110, 0, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 2'b00, 4'b1101, 1, 0, 0);
    cyc("mov", ex(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0), ex(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0));
    drv(1, 1, 2'b00, 4'b1111, 1, 0, 0);
    cyc("mvn", ex(1, 4'b1001, 0, 0, 1, 1, 0, 0, 0), ex(1, 4'b1001, 0, 0, 1, 1, 0, 0, 0));
    drv(1, 0, 2'b00, 4'b0001, 1, 0, 0);
    cyc("eor", ex(1, 4'b1000, 0, 0, 1, 0, 0, 0, 0), ex(1, 4'b1000, 0, 0, 1, 0, 0, 0, 0));
    drv(1, 0, 2'b00, 4'b0110, 1, 0, 0);
    cyc("sbc", ex(1, 4'b0101, 0, 0, 1, 0, 0, 0, 0), ex(1, 4'b0101, 0, 0, 1, 0, 0, 0, 0));

    // Illegal encodings
    drv(1, 1, 2'b00, 4'b0111, 1, 0, 0);
    cyc("ill_op", ex(1, 4'b0000, 0, 0, 0, 0, 0, 1, 0), ex(1, 4'b0000, 0, 0, 0, 0, 0, 1, 0));
    drv(1, 1, 2'b11, 4'b0100, 1, 0, 0);
    cyc("ill_mode", ex(1, 4'b0000, 0, 0, 0, 0, 0, 1, 0), ex(1, 4'b0000, 0, 0, 0, 0, 0, 1, 0));

    // Branch
    drv(1, 1, 2'b10, 4'b0000, 1, 0, 0);
    cyc("branch", ex(1, 4'b0000, 0, 0, 0, 0, 1, 0, 0), ex(1, 4'b0000, 0, 0, 0, 0, 1, 0, 0));

    // Bubbles and squash
    drv(1, 0, 2'b00, 4'b1101, 1, 1, 1);
    cyc("hz_fl", nop_st, nop_st);
    drv(1, 0, 2'b00, 4'b1101, 1, 0, 1);
    cyc("flush", bub, bub);
    drv(1, 0, 2'b00, 4'b1101, 1, 1, 0);
    cyc("hazard", nop_st, nop_st);
    drv(0, 0, 2'b00, 4'b1101, 1, 0, 0);
    cyc("no_valid", bub, bub);
    drv(1, 0, 2'b00, 4'b1101, 0, 0, 0);
    cyc("cond_fail", ex(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0), ex(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 2'b01, 4'b0000, 0, 0, 0);
    cyc("mem_cond_fail", ex(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0), ex(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 2'b00, 4'b0100, 1, 0, 0);
    cyc("no_wait", add0, add0);

    // LDR held for MEM_LAT cycles, ADD waiting in ID
    drv(1, 1, 2'b01, 4'b0000, 1, 0, 0);
    cyc("ldr_1", ldr, ldr);
    drv(1, 0, 2'b00, 4'b0100, 1, 0, 0);
    cyc("ldr_2", ldr, ldr);
    cyc("ldr_3", ldr & ~12'h1, ldr);
    cyc("ldr_4", add0, ldr & ~12'h1);
    cyc("ldr_5", add0, add0);

    // STR with flush during MEM_WAIT
    drv(1, 0, 2'b01, 4'b0000, 1, 0, 0);
    cyc("str_1", str, str);
    drv(1, 0, 2'b00, 4'b1101, 1, 0, 1);
    cyc("str_fl_2", str, str);
    cyc("str_fl_3", str & ~12'h1, str);
    cyc("str_fl_4", bub, str & ~12'h1);
    drv(1, 0, 2'b00, 4'b1101, 1, 0, 0);
    cyc("str_fl_5", ex(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0), ex(1, 4'b0001, 0, 0, 1, 0, 0, 0, 0));

    // STR aborted by reset in its second cycle
    drv(1, 0, 2'b01, 4'b0000, 1, 0, 0);
    cyc("str_rst_1", str, str);
    rst_n = 1'b0;
    now("str_rst_2", 12'h0, 12'h0);
    cyc("str_rst_3", 12'h0, 12'h0);
    rst_n = 1'b1;
    drv(1, 0, 2'b00, 4'b0100, 1, 0, 0);
    cyc("post_rst", add0, add0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
